// File: rtl/result_drain_pkg.sv
// Shared constants, state encoding and frame-length helper for result_drain.
// The optional trailing checksum beat is controlled by RESULT_DRAIN_CHECKSUM_EN.
package result_drain_pkg;

  localparam int N     = 8;
  localparam int DW    = 16;
  localparam int IW    = $clog2(N);
  localparam int ELEMS = N * N;

`ifdef RESULT_DRAIN_CHECKSUM_EN
  localparam bit CHECKSUM_EN = 1'b1;
`else
  localparam bit CHECKSUM_EN = 1'b0;
`endif

  localparam int FRAME_LEN = CHECKSUM_EN ? ELEMS + 1 : ELEMS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  // Beats per frame for a matrix of the given element count.
  function automatic int frame_len(input int elems);
    return CHECKSUM_EN ? elems + 1 : elems;
  endfunction

endpackage

// File: rtl/drain_addr_gen.sv
// Beat index plus row/column counters for the drain stream. Row and column
// advance alongside idx so no divide/modulo is needed.
module drain_addr_gen
  import result_drain_pkg::*;
#(
  parameter int N     = result_drain_pkg::N,
  parameter int IW    = $clog2(N),
  parameter int FRAME = frame_len(N * N),
  parameter int XW    = $clog2(FRAME + 1)
) (
  input  logic          m_clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] idx,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last
);

  always_ff @(posedge m_clk) begin
    if (rst || clear) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (advance) begin
      idx <= idx + XW'(1);
      if (col == IW'(N - 1)) begin
        col <= '0;
        // Row returns to 0 after the last element, which is where the checksum beat reports.
        row <= (row == IW'(N - 1)) ? '0 : row + IW'(1);
      end else begin
        col <= col + IW'(1);
      end
    end
  end

  assign last = (idx == XW'(FRAME - 1));

endmodule

// File: rtl/result_drain.sv
// Captures the N x N result matrix on the rising edge of done and streams it
// row-major over valid/ready. Optional checksum beat: RESULT_DRAIN_CHECKSUM_EN.
//   state    | meaning
//   IDLE     | armed, waiting for a done rising edge
//   STREAM   | presenting snapshot beats, out_valid high
//   WAIT_CLR | frame sent, waiting for done to drop before re-arming
module result_drain
  import result_drain_pkg::*;
#(
  parameter int N  = result_drain_pkg::N,
  parameter int DW = result_drain_pkg::DW,
  parameter int IW = $clog2(N)
) (
  input  logic              m_clk,
  input  logic              rst,
  input  logic              done,
  input  logic [N*N*DW-1:0] c_flat,
  output logic [DW-1:0]     out_data,
  output logic [IW-1:0]     out_row,
  output logic [IW-1:0]     out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int TOTAL = N * N;
  localparam int FRAME = frame_len(TOTAL);
  localparam int XW    = $clog2(FRAME + 1);
  localparam int AW    = $clog2(TOTAL);

  state_t          state, state_nxt;
  logic            done_q;
  logic            capture;
  logic            advance;
  logic            last;
  logic [XW-1:0]   idx;
  logic [IW-1:0]   row, col;
  logic [DW-1:0]   snap [TOTAL];

  // done_q tracks done even through reset, so a level still high afterwards is not an edge.
  always_ff @(posedge m_clk) begin
    done_q <= done;
  end

  always_ff @(posedge m_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    advance   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (done && !done_q) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          advance = 1'b1;
          if (last) state_nxt = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (rst) begin
      for (int i = 0; i < TOTAL; i++) snap[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < TOTAL; i++) snap[i] <= c_flat[i*DW +: DW];
    end
  end

  drain_addr_gen #(
    .N     (N),
    .IW    (IW),
    .FRAME (FRAME),
    .XW    (XW)
  ) u_addr (
    .m_clk   (m_clk),
    .rst     (rst),
    .clear   (capture),
    .advance (advance),
    .idx     (idx),
    .row     (row),
    .col     (col),
    .last    (last)
  );

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [DW-1:0] sum;

  // Accumulates exactly the data beats the consumer accepted.
  always_ff @(posedge m_clk) begin
    if (rst || capture) begin
      sum <= '0;
    end else if (advance && (idx < XW'(TOTAL))) begin
      sum <= sum + out_data;
    end
  end
`endif

  always_comb begin
    out_data = '0;
    if (state == STREAM) begin
`ifdef RESULT_DRAIN_CHECKSUM_EN
      if (idx == XW'(TOTAL)) out_data = sum;
      else                   out_data = snap[idx[AW-1:0]];
`else
      out_data = snap[idx[AW-1:0]];
`endif
    end
  end

  assign out_row  = row;
  assign out_col  = col;
  assign out_last = (state == STREAM) && last;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: scoreboard of expected beats plus a
// table of frame scenarios and hand-written reset / recapture sequences.
module tb_result_drain;

  localparam int TN  = 8;
  localparam int TDW = 16;
  localparam int TIW = 3;
  localparam int TE  = TN * TN;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  localparam int TF = TE + 1;
`else
  localparam int TF = TE;
`endif

  logic                m_clk;
  logic                rst;
  logic                done;
  logic [TE*TDW-1:0]   c_flat;
  logic [TDW-1:0]      out_data;
  logic [TIW-1:0]      out_row;
  logic [TIW-1:0]      out_col;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;

  result_drain dut (
    .m_clk     (m_clk),
    .rst       (rst),
    .done      (done),
    .c_flat    (c_flat),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  typedef struct packed {
    logic [TDW-1:0] data;
    logic [TIW-1:0] row;
    logic [TIW-1:0] col;
    logic           last;
  } beat_t;

  typedef struct {
    string name;
    int    pat;
    int    rmode;
    int    exp_cycles;
  } vec_t;

  beat_t          exp_q[$];
  logic [TDW-1:0] mat [TE];
  int             n_checks = 0;
  int             n_fail   = 0;
  int             beats    = 0;
  logic           stall_q  = 1'b0;
  beat_t          hold_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  task automatic fill_mat(input int pat);
    for (int i = 0; i < TE; i++) begin
      case (pat)
        0:       mat[i] = 16'h0002;
        1:       mat[i] = 16'(i);
        2:       mat[i] = 16'h1234;
        4:       mat[i] = 16'hFFFF;
        5:       mat[i] = 16'h55AA ^ 16'(i * 3);
        default: mat[i] = 16'($urandom);
      endcase
    end
    for (int i = 0; i < TE; i++) c_flat[i*TDW +: TDW] = mat[i];
  endtask

  task automatic push_model();
    beat_t          b;
    logic [TDW-1:0] sum;
    sum = '0;
    for (int i = 0; i < TE; i++) begin
      b.data = mat[i];
      b.row  = TIW'(i / TN);
      b.col  = TIW'(i % TN);
      b.last = (i == TF - 1);
      exp_q.push_back(b);
      sum = sum + mat[i];
    end
`ifdef RESULT_DRAIN_CHECKSUM_EN
    b.data = sum;
    b.row  = '0;
    b.col  = '0;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // Monitor: transfers are decided by the values seen half a cycle before the edge.
  always @(negedge m_clk) begin
    beat_t e;
    beat_t a;
    a = {out_data, out_row, out_col, out_last};
    if (stall_q) begin
      n_checks++;
      if (!out_valid || a !== hold_q) begin
        n_fail++;
        $display("FAIL hold: got valid=%0b %h, expected valid=1 %h", out_valid, a, hold_q);
      end
    end
    stall_q = out_valid && !out_ready;
    hold_q  = a;
    if (out_valid && out_ready) begin
      beats++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat %0d: got data=%h row=%0d col=%0d last=%0b, expected no beat",
                 beats, out_data, out_row, out_col, out_last);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL beat %0d: got data=%h row=%0d col=%0d last=%0b, expected data=%h row=%0d col=%0d last=%0b",
                   beats, out_data, out_row, out_col, out_last, e.data, e.row, e.col, e.last);
        end
      end
    end
  end

  task automatic start_frame(input string name);
    beats = 0;
    done  = 1'b1;
    step();
    check({name, "_latency_valid"}, {62'd0, out_valid, busy}, 64'd3);
    check({name, "_first_rc"}, {out_row, out_col}, 64'd0);
  endtask

  task automatic drain(input int rmode, output int cyc);
    bit tog;
    tog = 1'b1;
    cyc = 0;
    while (busy && cyc < 2000) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = tog; tog = !tog; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      cyc++;
    end
    check("frame_end_timeout", busy, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int cyc;
    fill_mat(v.pat);
    push_model();
    start_frame(v.name);
    drain(v.rmode, cyc);
    check({v.name, "_beats"}, beats, TF);
    if (v.exp_cycles >= 0) check({v.name, "_cycles"}, cyc, v.exp_cycles);
    check({v.name, "_queue_empty"}, exp_q.size(), 0);
    out_ready = 1'b1;
    repeat (4) step();
    check({v.name, "_wait_clr_idle"}, {62'd0, out_valid, busy}, 64'd0);
    check({v.name, "_no_extra_beats"}, beats, TF);
    done = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    vec_t tbl [4];
    int   cyc;

    tbl[0] = '{name: "all2",   pat: 0, rmode: 0, exp_cycles: TF};
    tbl[1] = '{name: "ramp",   pat: 1, rmode: 1, exp_cycles: 2 * TF - 1};
    tbl[2] = '{name: "h1234",  pat: 2, rmode: 0, exp_cycles: TF};
    tbl[3] = '{name: "random", pat: 3, rmode: 2, exp_cycles: -1};

    rst       = 1'b1;
    done      = 1'b0;
    out_ready = 1'b0;
    c_flat    = '0;
    repeat (3) step();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_row", out_row, 0);
    check("rst_col", out_col, 0);
    check("rst_last", out_last, 0);
    rst = 1'b0;
    repeat (2) step();
    check("idle_valid", out_valid, 0);

    for (int s = 0; s < 4; s++) run_frame(tbl[s]);

    // Input overwritten mid-frame plus a spurious done pulse: frame is untouched.
    fill_mat(1);
    push_model();
    out_ready = 1'b1;
    start_frame("overwrite");
    cyc = 0;
    while (beats < 10 && cyc < 200) begin step(); cyc++; end
    check("overwrite_reach10", beats >= 10, 1);
    fill_mat(4);
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    drain(0, cyc);
    check("overwrite_beats", beats, TF);
    check("overwrite_queue_empty", exp_q.size(), 0);
    repeat (4) step();
    check("overwrite_no_recapture", {62'd0, out_valid, busy}, 64'd0);
    done = 1'b0;
    repeat (2) step();

    // Reset mid-frame with done held high across it.
    fill_mat(1);
    push_model();
    out_ready = 1'b1;
    start_frame("rstmid");
    cyc = 0;
    while (beats < 20 && cyc < 200) begin step(); cyc++; end
    rst = 1'b1;
    step();
    check("rstmid_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_outputs", {out_data, out_row, out_col, out_last}, 0);
    exp_q.delete();
    rst = 1'b0;
    repeat (4) step();
    check("rstmid_done_high_no_capture", {62'd0, out_valid, busy}, 64'd0);
    done = 1'b0;
    step();
    fill_mat(5);
    push_model();
    start_frame("restart");
    check("restart_data0", out_data, mat[0]);
    drain(0, cyc);
    check("restart_beats", beats, TF);
    check("restart_queue_empty", exp_q.size(), 0);
    done = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_drain.md
# result_drain

Read-side companion to the systolic-array multiplier. It captures the full N×N 16-bit result matrix once the multiplier signals completion, then streams the elements out one per beat, row-major, over a valid/ready handshake. It sits between the multiplier's C outputs and any downstream consumer (host bridge, UART packer, FIFO), so the result matrix no longer has to be brought out as 64 parallel buses.

## Interface
Parameters:
- N, 8, array dimension; matrix holds N*N elements
- DW, 16, result element width
- IW, $clog2(N), row/column index width

Ports:
- m_clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- done  in  1  multiplier finished (level, the accelerator stop flag); rising edge triggers capture
- c_flat  in  N*N*DW  result matrix; element (r,c) at bits [(r*N+c)*DW +: DW]
- out_data  out  DW  current element
- out_row  out  IW  row index of out_data
- out_col  out  IW  column index of out_data
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_last  out  1  final beat of the frame
- busy  out  1  high from capture until the last beat is accepted

## Operation
- States: IDLE, STREAM, WAIT_CLR.
- IDLE: register done into done_q. When done=1 and done_q=0, load all N*N elements of c_flat into the snapshot bank, clear index to 0, and go to STREAM.
- STREAM: out_valid=1. out_data is snapshot[idx], with out_row=idx/N and out_col=idx%N. A beat transfers on a posedge where out_valid and out_ready are both 1, and idx then increments.
- out_last=1 only while idx=N*N-1 (or on the checksum beat when enabled).
- After the last beat transfers, go to WAIT_CLR.
- WAIT_CLR: out_valid=0. Return to IDLE when done=0, which re-arms the block for the next frame.
- Rising edges of done during STREAM or WAIT_CLR are ignored. There is no recapture and the snapshot is not disturbed.
- c_flat changing after capture has no effect on the frame being streamed.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, state=IDLE, idx=0, snapshot cleared.
- Latency: if the done rising edge is sampled at posedge t, out_valid=1 with element (0,0) after posedge t. busy rises at the same edge.
- Throughput: 1 beat per cycle with out_ready held high, so the frame takes N*N cycles (64 at N=8).
- Handshake: while out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold stable. out_valid never drops mid-frame.
- Last beat: at the posedge where the last beat transfers, out_valid, out_last and busy all fall.
- Index wrap: idx never wraps inside a frame and is cleared only on capture.
- Reset mid-frame: the next posedge with rst=1 forces all reset values and the partial frame is discarded. If done is still high after rst releases, it must go low and then high again before a new capture.

## Configuration
- RESULT_DRAIN_CHECKSUM_EN defined:
  - After element N*N-1, one extra beat is sent. Its out_data is the 16-bit modular sum of all N*N snapshot elements, with out_row=0 and out_col=0.
  - out_last moves to this extra beat, so the frame is N*N+1 beats.
  - The sum is accumulated as beats are accepted.
- Not defined: the frame is exactly N*N beats and the checksum logic is absent.

## Structure
- Shared package: N, DW, IW, ELEMS=N*N, the state enum (IDLE/STREAM/WAIT_CLR), and the frame-length constant (ELEMS, or ELEMS+1 with checksum).
- One sub-module: drain_addr_gen. It holds idx plus row/col counters, incremented on beat transfer, and exposes out_row, out_col and the last flag, avoiding divide/modulo logic.
- Snapshot bank and output mux stay in result_drain.

## Test plan
- Identity × all-2 matrix: C(r,c)=2 everywhere, done rises, out_ready=1.
  - 64 beats of 0x0002 in consecutive cycles.
  - out_last only on (7,7); busy low afterwards.
- Ramp C(r,c)=r*8+c, out_ready toggled 1,0,1,0:
  - Beats arrive in order 0..63 with correct row/col.
  - Data is held stable during every ready=0 cycle.
- done held high after the frame: state stays in WAIT_CLR and out_valid=0.
  - done 0 then 1 with a new matrix (all 0x1234): a second frame of 0x1234.
- c_flat overwritten with 0xFFFF at beat 10: remaining beats still carry the captured values.
  - A second done pulse mid-frame is ignored.
- rst asserted at beat 20: next cycle out_valid=0, busy=0, all outputs zero.
  - A fresh done edge restarts the frame at (0,0).
- With RESULT_DRAIN_CHECKSUM_EN, ramp matrix: 65 beats.
  - Beat 65 data is 0x07E0 (sum 0..63 = 2016), with out_last on beat 65 only.
